// File: rtl/if_id_skid_reg_if.sv
// IF/ID boundary bundle: fetch-side handshake, flush, decode-side beat
// and the pre-sliced decode fields.
interface if_id_skid_reg_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               flush;

    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    out_pc_plus4;
    logic [INSTR_W-1:0] out_instr;
    logic [4:0]         out_rs;
    logic [4:0]         out_rt;
    logic [4:0]         out_rd;
    logic [4:0]         out_shamt;
    logic [15:0]        out_imm16;
    logic [25:0]        out_jt;
    logic [CNT_W-1:0]   flush_count;

    modport slave (
        input  in_valid,
        input  in_pc,
        input  in_instr,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_pc,
        output out_pc_plus4,
        output out_instr,
        output out_rs,
        output out_rt,
        output out_rd,
        output out_shamt,
        output out_imm16,
        output out_jt,
        output flush_count
    );

    modport master (
        output in_valid,
        output in_pc,
        output in_instr,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_pc,
        input  out_pc_plus4,
        input  out_instr,
        input  out_rs,
        input  out_rt,
        input  out_rd,
        input  out_shamt,
        input  out_imm16,
        input  out_jt,
        input  flush_count
    );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with optional one-entry skid buffer, synchronous
// flush and a saturating count of flushes that discarded live entries.
module if_id_skid_reg #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int SKID    = 1,
    parameter int CNT_W   = 16
) (
    input logic            clk,
    input logic            reset,
    if_id_skid_reg_if.slave bus
);
    logic               main_v_q, main_v_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [PC_W-1:0]    main_pc4_q, main_pc4_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;

    logic               skid_v_q, skid_v_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [PC_W-1:0]    skid_pc4_q, skid_pc4_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_ready;
    logic               acc;
    logic               pop;
    logic [PC_W-1:0]    in_pc4;

    // With the skid enabled, ready depends only on state, never on out_ready.
    assign in_ready = (SKID != 0) ? ~skid_v_q
                                  : (~main_v_q | bus.out_ready);
    assign acc      = bus.in_valid & in_ready;
    assign pop      = main_v_q & bus.out_ready;
    assign in_pc4   = bus.in_pc + PC_W'(4);

    always_comb begin
        main_v_d     = main_v_q;
        main_pc_d    = main_pc_q;
        main_pc4_d   = main_pc4_q;
        main_instr_d = main_instr_q;
        skid_v_d     = skid_v_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        skid_instr_d = skid_instr_q;
        cnt_d        = cnt_q;

        if (bus.flush) begin
            main_v_d     = 1'b0;
            skid_v_d     = 1'b0;
            main_instr_d = '0;
            if ((main_v_q | skid_v_q) && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + CNT_W'(1);
        end else if (SKID != 0) begin
            unique case (1'b1)
                (!main_v_q && !skid_v_q): begin
                    if (acc) begin
                        main_v_d     = 1'b1;
                        main_pc_d    = bus.in_pc;
                        main_pc4_d   = in_pc4;
                        main_instr_d = bus.in_instr;
                    end
                end
                (main_v_q && !skid_v_q): begin
                    if (acc && pop) begin
                        main_pc_d    = bus.in_pc;
                        main_pc4_d   = in_pc4;
                        main_instr_d = bus.in_instr;
                    end else if (acc) begin
                        skid_v_d     = 1'b1;
                        skid_pc_d    = bus.in_pc;
                        skid_pc4_d   = in_pc4;
                        skid_instr_d = bus.in_instr;
                    end else if (pop) begin
                        main_v_d     = 1'b0;
                    end
                end
                skid_v_q: begin
                    // Skid refills main; the main-empty case is unreachable.
                    if (pop || !main_v_q) begin
                        main_v_d     = 1'b1;
                        main_pc_d    = skid_pc_q;
                        main_pc4_d   = skid_pc4_q;
                        main_instr_d = skid_instr_q;
                        skid_v_d     = 1'b0;
                    end
                end
            endcase
        end else begin
            if (acc) begin
                main_v_d     = 1'b1;
                main_pc_d    = bus.in_pc;
                main_pc4_d   = in_pc4;
                main_instr_d = bus.in_instr;
            end else if (pop) begin
                main_v_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v_q     <= 1'b0;
            main_pc_q    <= '0;
            main_pc4_q   <= '0;
            main_instr_q <= '0;
            skid_v_q     <= 1'b0;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            skid_instr_q <= '0;
            cnt_q        <= '0;
        end else begin
            main_v_q     <= main_v_d;
            main_pc_q    <= main_pc_d;
            main_pc4_q   <= main_pc4_d;
            main_instr_q <= main_instr_d;
            skid_v_q     <= skid_v_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_instr_q <= skid_instr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = main_v_q;
    assign bus.out_pc       = main_pc_q;
    assign bus.out_pc_plus4 = main_pc4_q;
    assign bus.out_instr    = main_instr_q;
    assign bus.out_rs       = main_instr_q[25:21];
    assign bus.out_rt       = main_instr_q[20:16];
    assign bus.out_rd       = main_instr_q[15:11];
    assign bus.out_shamt    = main_instr_q[10:6];
    assign bus.out_imm16    = main_instr_q[15:0];
    assign bus.out_jt       = main_instr_q[25:0];
    assign bus.flush_count  = cnt_q;
endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: a SKID=1/CNT_W=2 build and a SKID=0 build,
// each with an expected-beat queue checked by a decoupled output monitor.
module tb_if_id_skid_reg;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    int   pops_a;
    int   pops_b;
    beat_t q_a[$];
    beat_t q_b[$];

    if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32), .CNT_W(2))  bus_a ();
    if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32), .CNT_W(16)) bus_b ();

    if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .SKID(1), .CNT_W(2)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .SKID(0), .CNT_W(16)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [157:0] exp_vec(beat_t e);
        logic [31:0] p4;
        p4 = e.pc + 32'd4;
        return {e.pc, p4, e.instr, e.instr[25:21], e.instr[20:16],
                e.instr[15:11], e.instr[10:6], e.instr[15:0], e.instr[25:0]};
    endfunction

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            q_a.delete();
        end else begin
            if (bus_a.out_valid && bus_a.out_ready) begin
                pops_a++;
                if (q_a.size() == 0) begin
                    n_chk++;
                    $display("FAIL a_unexpected: got beat pc=%h, want none",
                             bus_a.out_pc);
                end else begin
                    e = q_a.pop_front();
                    chk("a_beat",
                        {bus_a.out_pc, bus_a.out_pc_plus4, bus_a.out_instr,
                         bus_a.out_rs, bus_a.out_rt, bus_a.out_rd,
                         bus_a.out_shamt, bus_a.out_imm16, bus_a.out_jt},
                        exp_vec(e));
                end
            end
            if (bus_a.flush) q_a.delete();
            else if (bus_a.in_valid && bus_a.in_ready)
                q_a.push_back('{bus_a.in_pc, bus_a.in_instr});
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            q_b.delete();
        end else begin
            if (bus_b.out_valid && bus_b.out_ready) begin
                pops_b++;
                if (q_b.size() == 0) begin
                    n_chk++;
                    $display("FAIL b_unexpected: got beat pc=%h, want none",
                             bus_b.out_pc);
                end else begin
                    e = q_b.pop_front();
                    chk("b_beat",
                        {bus_b.out_pc, bus_b.out_pc_plus4, bus_b.out_instr,
                         bus_b.out_rs, bus_b.out_rt, bus_b.out_rd,
                         bus_b.out_shamt, bus_b.out_imm16, bus_b.out_jt},
                        exp_vec(e));
                end
            end
            if (bus_b.flush) q_b.delete();
            else if (bus_b.in_valid && bus_b.in_ready)
                q_b.push_back('{bus_b.in_pc, bus_b.in_instr});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(logic v, logic [31:0] pc, logic [31:0] ins);
        bus_a.in_valid = v;
        bus_a.in_pc    = pc;
        bus_a.in_instr = ins;
    endtask

    task automatic drv_b(logic v, logic [31:0] pc, logic [31:0] ins);
        bus_b.in_valid = v;
        bus_b.in_pc    = pc;
        bus_b.in_instr = ins;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sat_exp [3];
        sat_exp = '{2'd3, 2'd3, 2'd3};
        n_chk  = 0;
        n_pass = 0;
        pops_a = 0;
        pops_b = 0;
        reset  = 1'b1;
        drv_a(1'b0, 32'h0, 32'h0);
        drv_b(1'b0, 32'h0, 32'h0);
        bus_a.flush = 1'b0;
        bus_b.flush = 1'b0;
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;

        tick();
        chk("rst_a_valid", bus_a.out_valid, 0);
        chk("rst_a_ready", bus_a.in_ready, 1);
        chk("rst_a_pcs", {bus_a.out_pc, bus_a.out_pc_plus4, bus_a.out_instr}, 0);
        chk("rst_a_fields", {bus_a.out_rs, bus_a.out_imm16, bus_a.out_jt}, 0);
        chk("rst_a_cnt", bus_a.flush_count, 0);
        chk("rst_b_ready", bus_b.in_ready, 1);
        reset = 1'b0;

        // streaming, one beat per cycle
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv_a(1'b1, 32'(4 * i), 32'h012A4020);
            tick();
            chk("str_valid", bus_a.out_valid, 1);
            chk("str_pc", bus_a.out_pc, 32'(4 * i));
            chk("str_pc4", bus_a.out_pc_plus4, 32'(4 * i + 4));
            chk("str_fields", {bus_a.out_rs, bus_a.out_rt, bus_a.out_rd},
                {5'd9, 5'd10, 5'd8});
        end
        drv_a(1'b0, 32'h0, 32'h0);
        tick();
        chk("str_drain", bus_a.out_valid, 0);

        // backpressure into the skid
        bus_a.out_ready = 1'b0;
        drv_a(1'b1, 32'h100, 32'h8C430004);
        tick();
        chk("bp_ready0", bus_a.in_ready, 1);
        drv_a(1'b1, 32'h104, 32'h00A62822);
        tick();
        chk("bp_full_ready", bus_a.in_ready, 0);
        chk("bp_main_pc", bus_a.out_pc, 32'h100);
        drv_a(1'b1, 32'h108, 32'h08000040);
        tick();
        chk("bp_hold_ready", bus_a.in_ready, 0);
        chk("bp_hold_instr", bus_a.out_instr, 32'h8C430004);
        bus_a.out_ready = 1'b1;
        chk("bp_ready_lag", bus_a.in_ready, 0);
        tick();
        chk("bp_skid_pc", bus_a.out_pc, 32'h104);
        chk("bp_ready_up", bus_a.in_ready, 1);
        tick();
        chk("bp_b2_pc", bus_a.out_pc, 32'h108);
        drv_a(1'b0, 32'h0, 32'h0);
        tick();
        chk("bp_drain", bus_a.out_valid, 0);

        // flush of FULL with a beat presented
        bus_a.out_ready = 1'b0;
        drv_a(1'b1, 32'h200, 32'h3C011234);
        tick();
        drv_a(1'b1, 32'h204, 32'h34215678);
        tick();
        drv_a(1'b1, 32'h208, 32'hAC220000);
        bus_a.flush = 1'b1;
        tick();
        bus_a.flush = 1'b0;
        drv_a(1'b0, 32'h0, 32'h0);
        chk("fl_valid", bus_a.out_valid, 0);
        chk("fl_instr", bus_a.out_instr, 0);
        chk("fl_fields", {bus_a.out_rt, bus_a.out_imm16, bus_a.out_jt}, 0);
        chk("fl_cnt1", bus_a.flush_count, 1);
        chk("fl_pc_hold", bus_a.out_pc, 32'h200);
        chk("fl_ready", bus_a.in_ready, 1);

        // flush drops a beat accepted in the same cycle
        drv_a(1'b1, 32'h300, 32'h00851020);
        tick();
        drv_a(1'b1, 32'h304, 32'h00C73022);
        bus_a.flush = 1'b1;
        tick();
        drv_a(1'b0, 32'h0, 32'h0);
        chk("fl2_valid", bus_a.out_valid, 0);
        chk("fl2_cnt2", bus_a.flush_count, 2);
        tick();
        bus_a.flush = 1'b0;
        chk("fl_empty_cnt", bus_a.flush_count, 2);

        // saturation at 3 with CNT_W=2
        for (int k = 0; k < 3; k++) begin
            drv_a(1'b1, 32'(32'h500 + 4 * k), 32'(k + 1));
            tick();
            drv_a(1'b0, 32'h0, 32'h0);
            bus_a.flush = 1'b1;
            tick();
            bus_a.flush = 1'b0;
            chk("sat_cnt", bus_a.flush_count, sat_exp[k]);
        end

        // async reset while FULL
        drv_a(1'b1, 32'h600, 32'h11111111);
        tick();
        drv_a(1'b1, 32'h604, 32'h22222222);
        tick();
        drv_a(1'b0, 32'h0, 32'h0);
        chk("pre_rst_full", bus_a.in_ready, 0);
        reset = 1'b1;
        #1;
        chk("arst_valid", bus_a.out_valid, 0);
        chk("arst_ready", bus_a.in_ready, 1);
        chk("arst_instr", bus_a.out_instr, 0);
        chk("arst_cnt", bus_a.flush_count, 0);
        chk("arst_pc", bus_a.out_pc, 0);
        tick();
        reset = 1'b0;

        // first accept after release
        bus_a.out_ready = 1'b1;
        drv_a(1'b1, 32'h400, 32'h03E00008);
        tick();
        chk("post_rst_pc", bus_a.out_pc, 32'h400);
        drv_a(1'b0, 32'h0, 32'h0);
        tick();
        chk("post_rst_drain", bus_a.out_valid, 0);

        // SKID=0 build: combinational ready and PC wrap
        drv_b(1'b1, 32'hFFFFFFFC, 32'h2108FFFF);
        tick();
        drv_b(1'b1, 32'h10, 32'h0C000123);
        chk("b_stall_ready", bus_b.in_ready, 0);
        chk("b_wrap_pc4", bus_b.out_pc_plus4, 32'h0);
        chk("b_imm16", bus_b.out_imm16, 16'hFFFF);
        chk("b_rs", bus_b.out_rs, 5'd8);
        bus_b.out_ready = 1'b1;
        #1;
        chk("b_comb_ready", bus_b.in_ready, 1);
        tick();
        chk("b_next_pc", bus_b.out_pc, 32'h10);
        chk("b_jt", bus_b.out_jt, 26'h0000123);
        drv_b(1'b0, 32'h0, 32'h0);
        tick();
        chk("b_drain", bus_b.out_valid, 0);

        tick();
        chk("a_pops", pops_a, 7);
        chk("b_pops", pops_b, 2);
        chk("a_left", q_a.size(), 0);
        chk("b_left", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
